// File: rtl/sssp_edge_fetch_if.sv
// Task-in, AR-request and config-write signals of the SSSP edge fetch stage.
// master is the fetch unit side, slave is the surrounding core / memory side.
interface sssp_edge_fetch_if #(
    parameter int TASK_W    = 32,
    parameter int SUBTYPE_W = 4
);
    logic                 task_in_valid;
    logic                 task_in_ready;
    logic [TASK_W-1:0]    in_task;
    logic [63:0]          in_data;

    logic                 arvalid;
    logic                 arready;
    logic [31:0]          araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [TASK_W-1:0]    resp_task;
    logic [SUBTYPE_W-1:0] resp_subtype;
    logic                 resp_mark_last;

    logic                 reg_wvalid;
    logic [7:0]           reg_waddr;
    logic [31:0]          reg_wdata;

    modport master (
        input  task_in_valid, in_task, in_data, arready,
               reg_wvalid, reg_waddr, reg_wdata,
        output task_in_ready, arvalid, araddr, arlen, arsize,
               resp_task, resp_subtype, resp_mark_last
    );

    modport slave (
        output task_in_valid, in_task, in_data, arready,
               reg_wvalid, reg_waddr, reg_wdata,
        input  task_in_ready, arvalid, araddr, arlen, arsize,
               resp_task, resp_subtype, resp_mark_last
    );
endinterface

// File: rtl/sssp_edge_fetch.sv
// SSSP neighbor fetch: turns a vertex task plus CSR offset pair into chunked read bursts.
// Optional end<start detection is enabled by defining SSSP_EDGE_FETCH_CHECK_EN.
module sssp_edge_fetch #(
    parameter int        MAX_BURST          = 16,
    parameter int        EDGE_SIZE_LOG2     = 3,
    parameter int        RESP_SUBTYPE       = 2,
    parameter int        TASK_W             = 32,
    parameter int        SUBTYPE_W          = 4,
    parameter logic [7:0] NEIGHBOR_BASE_ADDR = 8'h10
) (
    input  logic                  clk,
    input  logic                  rstn,
    sssp_edge_fetch_if.master     bus,
    output logic                  err_malformed
);
    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t            state;
    logic [31:0]       nbr_base;
    logic [31:0]       base_q;
    logic [31:0]       cur_q;
    logic [31:0]       end_q;
    logic [8:0]        beats_q;
    logic [TASK_W-1:0] task_q;

    logic [31:0] src_base, src_cur, src_end, rem;
    logic [31:0] nxt_addr;
    logic [8:0]  nxt_beats;
    logic [7:0]  nxt_len;
    logic        nxt_last;

`ifdef SSSP_EDGE_FETCH_CHECK_EN
    logic err_q;
    assign err_malformed = err_q;
`else
    assign err_malformed = 1'b0;
`endif

    assign bus.arsize       = 3'(EDGE_SIZE_LOG2);
    assign bus.resp_subtype = SUBTYPE_W'(RESP_SUBTYPE);
    assign bus.resp_task    = task_q;

    // Next burst comes from the incoming offsets in IDLE, otherwise from cur advanced past the current burst.
    always_comb begin
        src_base = base_q;
        src_cur  = cur_q + {23'd0, beats_q};
        src_end  = end_q;
        if (state == IDLE) begin
            src_base = nbr_base;
            src_cur  = bus.in_data[31:0];
            src_end  = bus.in_data[63:32];
        end
        rem       = src_end - src_cur;
        nxt_last  = (rem <= 32'(MAX_BURST));
        nxt_beats = nxt_last ? rem[8:0] : 9'(MAX_BURST);
        nxt_len   = 8'(nxt_beats - 9'd1);
        nxt_addr  = src_base + (src_cur << EDGE_SIZE_LOG2);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= IDLE;
            nbr_base           <= '0;
            base_q             <= '0;
            cur_q              <= '0;
            end_q              <= '0;
            beats_q            <= '0;
            task_q             <= '0;
            bus.arvalid        <= 1'b0;
            bus.araddr         <= '0;
            bus.arlen          <= '0;
            bus.resp_mark_last <= 1'b0;
            bus.task_in_ready  <= 1'b0;
`ifdef SSSP_EDGE_FETCH_CHECK_EN
            err_q              <= 1'b0;
`endif
        end else begin
            if (bus.reg_wvalid && bus.reg_waddr == NEIGHBOR_BASE_ADDR)
                nbr_base <= bus.reg_wdata << 2;

            case (state)
                IDLE: begin
                    if (bus.task_in_valid) begin
                        task_q <= bus.in_task;
                        cur_q  <= src_cur;
                        end_q  <= src_end;
                        base_q <= nbr_base;
                        if (src_end > src_cur) begin
                            state              <= ISSUE;
                            bus.arvalid        <= 1'b1;
                            bus.araddr         <= nxt_addr;
                            bus.arlen          <= nxt_len;
                            bus.resp_mark_last <= nxt_last;
                            beats_q            <= nxt_beats;
                        end else begin
                            state             <= ACK;
                            bus.task_in_ready <= 1'b1;
`ifdef SSSP_EDGE_FETCH_CHECK_EN
                            if (src_end < src_cur)
                                err_q <= 1'b1;
`endif
                        end
                    end
                end
                ISSUE: begin
                    if (bus.arready) begin
                        cur_q <= src_cur;
                        if (bus.resp_mark_last) begin
                            state              <= ACK;
                            bus.arvalid        <= 1'b0;
                            bus.resp_mark_last <= 1'b0;
                            bus.task_in_ready  <= 1'b1;
                        end else begin
                            bus.araddr         <= nxt_addr;
                            bus.arlen          <= nxt_len;
                            bus.resp_mark_last <= nxt_last;
                            beats_q            <= nxt_beats;
                        end
                    end
                end
                ACK: begin
                    bus.task_in_ready <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sssp_edge_fetch.sv
// Directed self-checking bench for sssp_edge_fetch; outputs are sampled on the falling edge.
module tb_sssp_edge_fetch;
    logic clk;
    logic rstn;
    logic err_malformed;
    int   checks   = 0;
    int   failures = 0;

    sssp_edge_fetch_if #(.TASK_W(32), .SUBTYPE_W(4)) bus ();

    sssp_edge_fetch #(
        .MAX_BURST(16), .EDGE_SIZE_LOG2(3), .RESP_SUBTYPE(2),
        .TASK_W(32), .SUBTYPE_W(4), .NEIGHBOR_BASE_ADDR(8'h10)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus.master),
        .err_malformed(err_malformed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SSSP_EDGE_FETCH_CHECK_EN
    localparam logic MALFORMED_ERR = 1'b1;
`else
    localparam logic MALFORMED_ERR = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge of cycle 1 after the capture edge.
    task automatic applyStimulus(input logic [31:0] tk, input logic [31:0] s, input logic [31:0] e);
        bus.task_in_valid = 1'b1;
        bus.in_task       = tk;
        bus.in_data       = {e, s};
        @(posedge clk);
        #1;
        bus.task_in_valid = 1'b0;
        bus.in_task       = 32'hDEAD_BEEF;
        bus.in_data       = '1;
        @(negedge clk);
    endtask

    task automatic writeBase(input logic [31:0] wdata);
        bus.reg_wvalid = 1'b1;
        bus.reg_waddr  = 8'h10;
        bus.reg_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.reg_wvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkAr(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic last, input logic [31:0] tk);
        checkOutput({tag, ".arvalid"}, 64'(bus.arvalid), 64'd1);
        checkOutput({tag, ".araddr"}, 64'(bus.araddr), 64'(addr));
        checkOutput({tag, ".arlen"}, 64'(bus.arlen), 64'(len));
        checkOutput({tag, ".last"}, 64'(bus.resp_mark_last), 64'(last));
        checkOutput({tag, ".task"}, 64'(bus.resp_task), 64'(tk));
        checkOutput({tag, ".ready"}, 64'(bus.task_in_ready), 64'd0);
    endtask

    task automatic checkIdle(input string tag, input logic ready);
        checkOutput({tag, ".arvalid"}, 64'(bus.arvalid), 64'd0);
        checkOutput({tag, ".ready"}, 64'(bus.task_in_ready), 64'(ready));
        checkOutput({tag, ".last"}, 64'(bus.resp_mark_last), 64'd0);
    endtask

    initial begin
        rstn              = 1'b0;
        bus.task_in_valid = 1'b0;
        bus.in_task       = '0;
        bus.in_data       = '0;
        bus.arready       = 1'b0;
        bus.reg_wvalid    = 1'b0;
        bus.reg_waddr     = '0;
        bus.reg_wdata     = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        nextCycle();
        checkIdle("reset", 1'b0);
        checkOutput("reset.araddr", 64'(bus.araddr), 64'd0);
        checkOutput("reset.arlen", 64'(bus.arlen), 64'd0);
        checkOutput("reset.err", 64'(err_malformed), 64'd0);

        $display("[TB] single burst");
        writeBase(32'h400);
        bus.arready = 1'b1;
        applyStimulus(32'hA001, 32'd10, 32'd13);
        checkAr("single", 32'h1050, 8'd2, 1'b1, 32'hA001);
        checkOutput("single.arsize", 64'(bus.arsize), 64'd3);
        checkOutput("single.subtype", 64'(bus.resp_subtype), 64'd2);
        nextCycle();
        checkIdle("single.ack", 1'b1);
        nextCycle();
        checkIdle("single.done", 1'b0);

        $display("[TB] split range");
        writeBase(32'h0);
        applyStimulus(32'hA002, 32'd0, 32'd40);
        checkAr("split.c0", 32'h000, 8'd15, 1'b0, 32'hA002);
        nextCycle();
        checkAr("split.c1", 32'h080, 8'd15, 1'b0, 32'hA002);
        nextCycle();
        checkAr("split.c2", 32'h100, 8'd7, 1'b1, 32'hA002);
        nextCycle();
        checkIdle("split.ack", 1'b1);
        nextCycle();
        checkIdle("split.done", 1'b0);

        $display("[TB] exactly MAX_BURST edges");
        applyStimulus(32'hA003, 32'd16, 32'd32);
        checkAr("exact.c0", 32'h080, 8'd15, 1'b1, 32'hA003);
        nextCycle();
        checkIdle("exact.ack", 1'b1);
        nextCycle();

        $display("[TB] zero degree");
        applyStimulus(32'hA004, 32'd5, 32'd5);
        checkIdle("zero.c1", 1'b1);
        checkOutput("zero.task", 64'(bus.resp_task), 64'hA004);
        nextCycle();
        checkIdle("zero.c2", 1'b0);

        $display("[TB] backpressure");
        bus.arready = 1'b0;
        applyStimulus(32'hA005, 32'd0, 32'd40);
        checkAr("bp.s1", 32'h000, 8'd15, 1'b0, 32'hA005);
        nextCycle();
        checkAr("bp.s2", 32'h000, 8'd15, 1'b0, 32'hA005);
        writeBase(32'h100);
        checkAr("bp.s3", 32'h000, 8'd15, 1'b0, 32'hA005);
        nextCycle();
        checkAr("bp.s4", 32'h000, 8'd15, 1'b0, 32'hA005);
        bus.arready = 1'b1;
        nextCycle();
        checkAr("bp.c1", 32'h080, 8'd15, 1'b0, 32'hA005);
        nextCycle();
        checkAr("bp.c2", 32'h100, 8'd7, 1'b1, 32'hA005);
        nextCycle();
        checkIdle("bp.ack", 1'b1);
        nextCycle();

        $display("[TB] new base on next task, single beat");
        applyStimulus(32'hA006, 32'd0, 32'd1);
        checkAr("newbase", 32'h400, 8'd0, 1'b1, 32'hA006);
        nextCycle();
        checkIdle("newbase.ack", 1'b1);
        nextCycle();

        $display("[TB] malformed range");
        applyStimulus(32'hA007, 32'd20, 32'd8);
        checkIdle("malformed.c1", 1'b1);
        checkOutput("malformed.err1", 64'(err_malformed), 64'(MALFORMED_ERR));
        nextCycle();
        checkIdle("malformed.c2", 1'b0);
        checkOutput("malformed.err2", 64'(err_malformed), 64'(MALFORMED_ERR));
        nextCycle();
        checkOutput("malformed.err3", 64'(err_malformed), 64'(MALFORMED_ERR));

        $display("[TB] reset mid-burst");
        applyStimulus(32'hA008, 32'd0, 32'd40);
        checkAr("rst.c0", 32'h400, 8'd15, 1'b0, 32'hA008);
        nextCycle();
        checkAr("rst.c1", 32'h480, 8'd15, 1'b0, 32'hA008);
        rstn = 1'b0;
        #1;
        checkIdle("rst.async", 1'b0);
        checkOutput("rst.araddr", 64'(bus.araddr), 64'd0);
        checkOutput("rst.err", 64'(err_malformed), 64'd0);
        nextCycle();
        nextCycle();
        checkIdle("rst.held", 1'b0);
        rstn = 1'b1;
        applyStimulus(32'hA008, 32'd0, 32'd40);
        checkAr("rerun.c0", 32'h000, 8'd15, 1'b0, 32'hA008);
        nextCycle();
        checkAr("rerun.c1", 32'h080, 8'd15, 1'b0, 32'hA008);
        nextCycle();
        checkAr("rerun.c2", 32'h100, 8'd7, 1'b1, 32'hA008);
        nextCycle();
        checkIdle("rerun.ack", 1'b1);
        nextCycle();
        checkIdle("rerun.done", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
